// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types for the ID-stage branch hazard controller: scoreboard entry layout,
// forward-select encoding and the Tnew saturating decrement.
package branch_hazard_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam int TNEW_W = 2;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [TNEW_W-1:0] tnew_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t waddr;
      tnew_t     tnew;
   } sb_entry_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_EX  = 2'd2
   } fwd_sel_e;

   function automatic tnew_t sat_dec(input tnew_t t);
      return (t == '0) ? t : tnew_t'(t - 1'b1);
   endfunction

endpackage

// File: rtl/branch_hazard_ctrl_fwd_sel_unit.sv
// Per-operand forward selection: finds the youngest in-flight writer of src and
// reports where the value comes from and whether it is available yet.
module fwd_sel_unit
   import branch_hazard_ctrl_pkg::*;
(
   input  reg_addr_t src,
   input  sb_entry_t ex_slot,
   input  sb_entry_t mem_slot,
   output fwd_sel_e  sel,
   output logic      ready
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_slot.valid  && (ex_slot.waddr  == src) && (src != '0);
   assign mem_hit = mem_slot.valid && (mem_slot.waddr == src) && (src != '0);

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      sel   = FWD_RF;
      ready = 1'b1;
      if (ex_hit) begin
         sel   = FWD_EX;
         ready = (ex_slot.tnew == '0);
      end else if (mem_hit) begin
         sel   = FWD_MEM;
         ready = (mem_slot.tnew == '0);
      end
   end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: EX/MEM Tnew scoreboard, comparator operand
// forwarding, stall and taken decision, and saturating performance counters.
module branch_hazard_ctrl
   import branch_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ext_hold,
   input  logic              id_valid,
   input  logic              id_is_branch,
   input  logic              id_is_bne,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_waddr,
   input  logic [TNEW_W-1:0] id_tnew,
   input  logic [31:0]       rf_rs_data,
   input  logic [31:0]       rf_rt_data,
   input  logic [31:0]       ex_fwd_data,
   input  logic [31:0]       mem_fwd_data,
   input  logic              cmp_equal,
   output logic [31:0]       cmp_a,
   output logic [31:0]       cmp_b,
   output logic              stall,
   output logic              br_taken,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  taken_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   sb_entry_t ex_q;
   sb_entry_t mem_q;
   sb_entry_t id_entry;
   sb_entry_t mem_next;
   fwd_sel_e  rs_sel;
   fwd_sel_e  rt_sel;
   logic      rs_ready;
   logic      rt_ready;
   logic      is_branch;
   logic      resolved;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

   function automatic logic [31:0] fwd_mux(input fwd_sel_e s, input logic [31:0] rf_d,
                                           input logic [31:0] ex_d, input logic [31:0] mem_d);
      case (s)
         FWD_EX:  return ex_d;
         FWD_MEM: return mem_d;
         default: return rf_d;
      endcase
   endfunction

   fwd_sel_unit u_rs_sel (
      .src      (id_rs),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (rs_sel),
      .ready    (rs_ready)
   );

   fwd_sel_unit u_rt_sel (
      .src      (id_rt),
      .ex_slot  (ex_q),
      .mem_slot (mem_q),
      .sel      (rt_sel),
      .ready    (rt_ready)
   );

   // Branches consume operands in ID (Tuse=0), so any not-yet-ready source stalls.
   assign is_branch = id_valid & id_is_branch;
   assign stall     = is_branch & ~(rs_ready & rt_ready);
   assign resolved  = is_branch & ~stall;
   assign br_taken  = resolved & ~ext_hold & (cmp_equal ^ id_is_bne);

   assign cmp_a = fwd_mux(rs_sel, rf_rs_data, ex_fwd_data, mem_fwd_data);
   assign cmp_b = fwd_mux(rt_sel, rf_rt_data, ex_fwd_data, mem_fwd_data);

   assign id_entry.valid = id_valid & id_wr_en & (id_waddr != '0);
   assign id_entry.waddr = id_waddr;
   assign id_entry.tnew  = id_tnew;

   assign mem_next.valid = ex_q.valid;
   assign mem_next.waddr = ex_q.waddr;
   assign mem_next.tnew  = sat_dec(ex_q.tnew);

   // NOTE: whole entries are cleared on reset, not just the valid bits, so stale
   // address/tnew fields never reach the comparators as X in simulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q       <= '0;
         mem_q      <= '0;
         branch_cnt <= '0;
         taken_cnt  <= '0;
         stall_cnt  <= '0;
      end else if (!ext_hold) begin
         mem_q <= mem_next;
         ex_q  <= stall ? sb_entry_t'('0) : id_entry;
         if (resolved) branch_cnt <= sat_inc(branch_cnt);
         if (br_taken) taken_cnt  <= sat_inc(taken_cnt);
         if (stall)    stall_cnt  <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed vector table, randomized
// stimulus against an age-based in-flight write model, and a narrow-counter instance.
module tb_branch_hazard_ctrl;
   import branch_hazard_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ext_hold, id_valid, id_is_branch, id_is_bne, id_wr_en, cmp_equal;
   logic [4:0]  id_rs, id_rt, id_waddr;
   logic [1:0]  id_tnew;
   logic [31:0] rf_rs_data, rf_rt_data, ex_fwd_data, mem_fwd_data;
   logic [31:0] cmp_a, cmp_b, cmp_a_s, cmp_b_s;
   logic        stall, br_taken, stall_s, br_taken_s;
   logic [31:0] branch_cnt, taken_cnt, stall_cnt;
   logic [2:0]  branch_cnt_s, taken_cnt_s, stall_cnt_s;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   branch_hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .ext_hold(ext_hold), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_is_bne(id_is_bne), .id_rs(id_rs), .id_rt(id_rt),
      .id_wr_en(id_wr_en), .id_waddr(id_waddr), .id_tnew(id_tnew),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_data(mem_fwd_data), .cmp_equal(cmp_equal), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .stall(stall), .br_taken(br_taken), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt),
      .stall_cnt(stall_cnt)
   );

   branch_hazard_ctrl #(.CNT_W(3)) dut_s (
      .clk(clk), .reset(reset), .ext_hold(ext_hold), .id_valid(id_valid),
      .id_is_branch(id_is_branch), .id_is_bne(id_is_bne), .id_rs(id_rs), .id_rt(id_rt),
      .id_wr_en(id_wr_en), .id_waddr(id_waddr), .id_tnew(id_tnew),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .ex_fwd_data(ex_fwd_data),
      .mem_fwd_data(mem_fwd_data), .cmp_equal(cmp_equal), .cmp_a(cmp_a_s), .cmp_b(cmp_b_s),
      .stall(stall_s), .br_taken(br_taken_s), .branch_cnt(branch_cnt_s),
      .taken_cnt(taken_cnt_s), .stall_cnt(stall_cnt_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each in-flight write remembers its Tnew and how many cycles
   // it has spent past ID (age 0 = EX, 1 = MEM); it is forwardable once age >= Tnew.
   typedef struct {int r; int tnew; int age;} wr_t;
   wr_t    infl[$];
   longint m_br, m_tk, m_st;

   function automatic void lookup(input int src, output int where, output bit rdy);
      where = 0;
      rdy   = 1'b1;
      if (src == 0) return;
      for (int a = 0; a < 2; a++)
         foreach (infl[i])
            if (infl[i].age == a && infl[i].r == src) begin
               where = (a == 0) ? 2 : 1;
               rdy   = (infl[i].tnew <= a);
               return;
            end
   endfunction

   function automatic logic [31:0] pick(input int where, input logic [31:0] rf_d);
      return (where == 2) ? ex_fwd_data : (where == 1) ? mem_fwd_data : rf_d;
   endfunction

   function automatic logic [31:0] sat7(input longint v);
      return (v > 7) ? 32'd7 : 32'(v);
   endfunction

   typedef struct {
      bit hold, valid, br, bne;
      int rs, rt;
      bit wr;
      int waddr, tnew;
      bit eq;
      bit e_stall, e_taken;
      int e_a, e_b;   // 0 rf, 1 mem, 2 ex, 3 not checked
   } vec_t;

   task automatic step(input bit rst, input vec_t v, input bit use_exp, input string tag);
      int  wa, wb;
      bit  ra, rb, m_stall, m_taken;
      reset        = rst;
      ext_hold     = v.hold;
      id_valid     = v.valid;
      id_is_branch = v.br;
      id_is_bne    = v.bne;
      id_rs        = 5'(v.rs);
      id_rt        = 5'(v.rt);
      id_wr_en     = v.wr;
      id_waddr     = 5'(v.waddr);
      id_tnew      = 2'(v.tnew);
      cmp_equal    = v.eq;
      rf_rs_data   = $urandom;
      rf_rt_data   = $urandom;
      ex_fwd_data  = $urandom;
      mem_fwd_data = $urandom;
      #4;
      lookup(v.rs, wa, ra);
      lookup(v.rt, wb, rb);
      m_stall = v.valid & v.br & !(ra & rb);
      m_taken = v.valid & v.br & !m_stall & !v.hold & (v.eq ^ v.bne);
      check({tag, " stall"}, 32'(stall), 32'(m_stall));
      check({tag, " br_taken"}, 32'(br_taken), 32'(m_taken));
      check({tag, " stall_s"}, 32'(stall_s), 32'(m_stall));
      check({tag, " br_taken_s"}, 32'(br_taken_s), 32'(m_taken));
      if (ra) check({tag, " cmp_a"}, cmp_a, pick(wa, rf_rs_data));
      if (rb) check({tag, " cmp_b"}, cmp_b, pick(wb, rf_rt_data));
      if (ra) check({tag, " cmp_a_s"}, cmp_a_s, pick(wa, rf_rs_data));
      check({tag, " branch_cnt"}, branch_cnt, 32'(m_br));
      check({tag, " taken_cnt"}, taken_cnt, 32'(m_tk));
      check({tag, " stall_cnt"}, stall_cnt, 32'(m_st));
      check({tag, " branch_cnt_s"}, 32'(branch_cnt_s), sat7(m_br));
      check({tag, " taken_cnt_s"}, 32'(taken_cnt_s), sat7(m_tk));
      check({tag, " stall_cnt_s"}, 32'(stall_cnt_s), sat7(m_st));
      if (use_exp) begin
         check({tag, " tbl stall"}, 32'(stall), 32'(v.e_stall));
         check({tag, " tbl br_taken"}, 32'(br_taken), 32'(v.e_taken));
         if (v.e_a != 3) check({tag, " tbl cmp_a"}, cmp_a, pick(v.e_a, rf_rs_data));
         if (v.e_b != 3) check({tag, " tbl cmp_b"}, cmp_b, pick(v.e_b, rf_rt_data));
      end
      if (rst) begin
         infl.delete();
         m_br = 0; m_tk = 0; m_st = 0;
      end else if (!v.hold) begin
         if (v.valid & v.br & !m_stall) m_br++;
         if (m_taken) m_tk++;
         if (m_stall) m_st++;
         foreach (infl[i]) infl[i].age++;
         while (infl.size() > 0 && infl[infl.size()-1].age > 1) void'(infl.pop_back());
         if (!m_stall && v.valid && v.wr && v.waddr != 0)
            infl.push_front('{r: v.waddr, tnew: v.tnew, age: 0});
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [24];
   vec_t idle;
   vec_t rv;

   initial begin
      //       hold val br bne rs  rt wr wa tn eq  st tk  a  b
      tbl = '{'{0, 1, 0, 0,  0,  0, 1, 8, 1, 0,  0, 0, 0, 0},
              '{0, 1, 1, 0,  8,  0, 0, 0, 0, 0,  1, 0, 3, 0},
              '{0, 1, 1, 0,  8,  0, 0, 0, 0, 0,  0, 0, 1, 0},
              '{0, 1, 0, 0,  0,  0, 1, 9, 2, 0,  0, 0, 0, 0},
              '{0, 1, 1, 1,  9,  9, 0, 0, 0, 1,  1, 0, 3, 3},
              '{0, 1, 1, 1,  9,  9, 0, 0, 0, 1,  1, 0, 3, 3},
              '{0, 1, 1, 1,  9,  9, 0, 0, 0, 1,  0, 0, 0, 0},
              '{0, 1, 0, 0,  0,  0, 1,10, 0, 0,  0, 0, 0, 0},
              '{0, 1, 1, 0, 10, 10, 0, 0, 0, 1,  0, 1, 2, 2},
              '{0, 1, 0, 0,  0,  0, 1,11, 0, 0,  0, 0, 0, 0},
              '{0, 1, 0, 0,  0,  0, 1,11, 0, 0,  0, 0, 0, 0},
              '{0, 1, 1, 0, 11,  0, 0, 0, 0, 0,  0, 0, 2, 0},
              '{0, 1, 0, 0,  0,  0, 1, 0, 2, 0,  0, 0, 0, 0},
              '{0, 1, 1, 0,  0,  0, 0, 0, 0, 1,  0, 1, 0, 0},
              '{0, 1, 0, 0,  0,  0, 1,12, 2, 0,  0, 0, 0, 0},
              '{1, 1, 1, 0, 12,  0, 0, 0, 0, 1,  1, 0, 3, 0},
              '{1, 1, 1, 0, 12,  0, 0, 0, 0, 1,  1, 0, 3, 0},
              '{1, 1, 1, 0, 12,  0, 0, 0, 0, 1,  1, 0, 3, 0},
              '{0, 1, 1, 0, 12,  0, 0, 0, 0, 1,  1, 0, 3, 0},
              '{0, 1, 1, 0, 12,  0, 0, 0, 0, 1,  1, 0, 3, 0},
              '{0, 1, 1, 0, 12,  0, 0, 0, 0, 1,  0, 1, 0, 0},
              '{0, 1, 0, 0,  0,  0, 1,13, 0, 0,  0, 0, 0, 0},
              '{1, 1, 1, 1, 13, 13, 0, 0, 0, 0,  0, 0, 2, 2},
              '{0, 1, 1, 1, 13, 13, 0, 0, 0, 0,  0, 1, 2, 2}};
      idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3};

      reset = 1'b1; ext_hold = 1'b0; id_valid = 1'b0; id_is_branch = 1'b0; id_is_bne = 1'b0;
      id_rs = '0; id_rt = '0; id_wr_en = 1'b0; id_waddr = '0; id_tnew = '0; cmp_equal = 1'b0;
      rf_rs_data = '0; rf_rt_data = '0; ex_fwd_data = '0; mem_fwd_data = '0;
      m_br = 0; m_tk = 0; m_st = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #4;
      check("reset branch_cnt", branch_cnt, 32'd0);
      check("reset taken_cnt", taken_cnt, 32'd0);
      check("reset stall_cnt", stall_cnt, 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      check("reset br_taken", 32'(br_taken), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) step(1'b0, tbl[i], 1'b1, $sformatf("vec%0d", i));

      // Reset while held with a stalled branch pending: everything must clear anyway.
      step(1'b0, '{0, 1, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0, 3, 3}, 1'b0, "pre_rst");
      step(1'b1, '{1, 1, 1, 0, 7, 0, 0, 0, 0, 0, 1, 0, 3, 3}, 1'b1, "rst_hold");
      step(1'b0, '{0, 1, 1, 0, 7, 0, 0, 0, 0, 1, 0, 1, 0, 0}, 1'b1, "post_rst");

      for (int n = 0; n < 400; n++) begin
         rv.hold  = ($urandom % 5) == 0;
         rv.valid = ($urandom % 8) != 0;
         rv.br    = $urandom % 2;
         rv.bne   = $urandom % 2;
         rv.rs    = $urandom % 4;
         rv.rt    = $urandom % 4;
         rv.wr    = ($urandom % 3) != 0;
         rv.waddr = $urandom % 4;
         rv.tnew  = $urandom % 4;
         rv.eq    = $urandom % 2;
         rv.e_stall = 0; rv.e_taken = 0; rv.e_a = 3; rv.e_b = 3;
         step(($urandom % 40) == 0, rv, 1'b0, $sformatf("rnd%0d", n));
      end

      // Saturation: five load(tnew=3)/branch pairs give ten stall cycles.
      step(1'b1, idle, 1'b0, "sat_rst");
      for (int k = 0; k < 5; k++) begin
         step(1'b0, '{0, 1, 0, 0, 0, 0, 1, 5, 3, 0, 0, 0, 0, 0}, 1'b1, "sat_ld");
         step(1'b0, '{0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 3, 0}, 1'b1, "sat_st1");
         step(1'b0, '{0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, 3, 0}, 1'b1, "sat_st2");
         step(1'b0, '{0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, "sat_go");
      end
      #4;
      check("sat stall_cnt", stall_cnt, 32'd10);
      check("sat stall_cnt_s", 32'(stall_cnt_s), 32'd7);
      check("sat branch_cnt", branch_cnt, 32'd5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
